ethernet_mmio_bridge: RTL and testbench
=======================================

Name: ethernet_mmio_bridge

Overview:
Host-side request/response adapter directly upstream of the Ethernet controller core's MMIO port. Accepts one valid/ready host request at a time and checks alignment. Converts it into a single-cycle read or write strobe on the controller interface. Captures the controller's one-cycle read data pulse and returns a held valid/ready response, so the host never has to sample a transient.

Parameters:
axis_width_p, 64, data width of host and controller data buses; must be 64.
addr_width_p, 16, MMIO address width.
timeout_cycles_p, 1024, read-wait limit in cycles; used only with the optional feature; must be ≥2.

Ports:
clk_i  input  1  sole clock
reset_n_i  input  1  asynchronous, active-low reset
in_v_i  input  1  host request valid
in_ready_o  output  1  bridge can accept a request
in_addr_i  input  addr_width_p  request byte address
in_we_i  input  1  1 = write, 0 = read
in_size_i  input  2  access size: 0 = 1B, 1 = 2B, 2 = 4B, 3 = 8B
in_data_i  input  axis_width_p  write data, right-aligned
resp_v_o  output  1  response valid
resp_ready_i  input  1  host accepts response
resp_data_o  output  axis_width_p  read data, zero-extended to size; 0 for writes and errors
resp_we_o  output  1  response belongs to a write
resp_err_o  output  1  misaligned access, or timeout when the optional feature is enabled
addr_o  output  addr_width_p  controller address
write_en_o  output  1  controller write strobe
read_en_o  output  1  controller read strobe
op_size_o  output  2  controller access size
write_data_o  output  axis_width_p  controller write data, masked to size
read_data_i  input  axis_width_p  controller read data; valid only while read_data_v_i = 1
read_data_v_i  input  1  controller read data valid; one-cycle pulse

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert): state IDLE.
  - All outputs 0 except in_ready_o = 1 in IDLE.
  - A reset asserted mid-operation drops any strobe and any pending response immediately, with no replay.
- States: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - in_ready_o = 1.
  - On in_v_i, register addr, we, size and data.
  - Misaligned request, i.e. addr & ((1<<size)-1) ≠ 0: go to RESP with err = 1 and data = 0. No strobe is issued.
  - Aligned request: go to ISSUE.
- ISSUE: exactly one cycle.
  - addr_o and op_size_o driven from the registered request.
  - write_en_o = we; read_en_o = ~we.
  - write_data_o = registered data ANDed with a size mask. Mask by size: 0xFF, 0xFFFF, 0xFFFF_FFFF, all-ones.
  - Write: go to RESP, err = 0, data = 0, resp_we_o = 1.
  - Read: go to WAIT_RD.
- addr_o, op_size_o and write_data_o are held constant from ISSUE until return to IDLE. They are 0 in IDLE.
- WAIT_RD:
  - On read_data_v_i, capture read_data_i ANDed with the size mask and go to RESP with err = 0.
  - read_data_v_i arriving in the same cycle as the ISSUE strobe is impossible (the controller read is synchronous) and need not be handled.
- RESP:
  - resp_v_o = 1; resp_data_o, resp_we_o and resp_err_o are stable while resp_v_o = 1 and resp_ready_i = 0.
  - On resp_ready_i, go to IDLE.
  - in_ready_o = 0, so a new request is not accepted in the same cycle.
- read_data_v_i outside WAIT_RD is ignored.
- Throughput: one transaction in flight.
  - Write: request accepted at cycle 0, strobe at 1, resp_v_o at 2.
  - Read: strobe at 1, read_data_v_i at 2, resp_v_o at 3.
  - Minimum request-to-request spacing: 3 cycles for a write, 4 for a read.
- Strobes are never asserted in any state other than ISSUE.

Optional Feature:
ETH_MMIO_BRIDGE_TIMEOUT_EN.
- Defined: a counter of width $clog2(timeout_cycles_p) clears on entry to WAIT_RD and increments each cycle in WAIT_RD.
  - If it reaches timeout_cycles_p-1 with no read_data_v_i, go to RESP with err = 1 and data = 0.
  - A read_data_v_i in that same cycle wins: normal data, err = 0.
  - A later pulse is ignored.
- Undefined: no counter; WAIT_RD waits indefinitely.

Test Plan:
- Aligned 8B write, addr 0x0010, data 0x1122334455667788 -> write_en_o pulse for 1 cycle with addr_o 0x0010, op_size_o 3, write_data_o 0x1122334455667788; resp_v_o at cycle 2, resp_we_o = 1, resp_err_o = 0.
- 2B read, addr 0x0802; controller returns 0xDEADBEEFCAFE1234 one cycle after read_en_o -> resp_data_o = 0x0000000000001234, err = 0; response held while resp_ready_i is held low for 5 cycles.
- Misaligned 4B read at addr 0x0006 -> no read_en_o or write_en_o; resp_v_o at cycle 1 with err = 1 and data 0.
- Spurious read_data_v_i in IDLE and in RESP -> no state change; response data unchanged.
- Assert reset_n_i low during WAIT_RD, then release -> all outputs 0 asynchronously; in_ready_o = 1 after release; a following 1B write completes normally.
- Timeout feature on, timeout_cycles_p = 8, no read_data_v_i -> resp_v_o with err = 1, 8 cycles after entering WAIT_RD; a late pulse is ignored.

Source files
------------

// File: rtl/ethernet_mmio_bridge.sv
// Host request/response adapter in front of the Ethernet controller MMIO port.
// Optional read-wait timeout: define ETH_MMIO_BRIDGE_TIMEOUT_EN.
module ethernet_mmio_bridge #(
    parameter int unsigned axis_width_p     = 64,
    parameter int unsigned addr_width_p     = 16,
    parameter int unsigned timeout_cycles_p = 1024
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    in_v_i,
    output logic                    in_ready_o,
    input  logic [addr_width_p-1:0] in_addr_i,
    input  logic                    in_we_i,
    input  logic [1:0]              in_size_i,
    input  logic [axis_width_p-1:0] in_data_i,
    output logic                    resp_v_o,
    input  logic                    resp_ready_i,
    output logic [axis_width_p-1:0] resp_data_o,
    output logic                    resp_we_o,
    output logic                    resp_err_o,
    output logic [addr_width_p-1:0] addr_o,
    output logic                    write_en_o,
    output logic                    read_en_o,
    output logic [1:0]              op_size_o,
    output logic [axis_width_p-1:0] write_data_o,
    input  logic [axis_width_p-1:0] read_data_i,
    input  logic                    read_data_v_i
);

    if (axis_width_p != 64 || timeout_cycles_p < 2) begin : g_param_check
        $error("ethernet_mmio_bridge: axis_width_p must be 64 and timeout_cycles_p >= 2");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

    state_t                  r_state;
    logic                    r_in_ready;
    logic                    r_we;
    logic [1:0]              r_size;
    logic [addr_width_p-1:0] r_addr;
    logic [axis_width_p-1:0] r_wdata;
    logic                    r_wen;
    logic                    r_ren;
    logic                    r_resp_v;
    logic                    r_resp_we;
    logic                    r_resp_err;
    logic [axis_width_p-1:0] r_resp_data;
    logic [2:0]              w_align_bits;
    logic                    w_misaligned;

`ifdef ETH_MMIO_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(timeout_cycles_p);
    logic [CNT_W-1:0] r_wait_cnt;
`endif

    function automatic logic [axis_width_p-1:0] size_mask(input logic [1:0] size);
        logic [axis_width_p-1:0] m;
        m = '0;
        case (size)
            2'd0:    m[7:0]  = '1;
            2'd1:    m[15:0] = '1;
            2'd2:    m[31:0] = '1;
            default: m       = '1;
        endcase
        return m;
    endfunction

    always_comb begin
        case (in_size_i)
            2'd0:    w_align_bits = 3'b000;
            2'd1:    w_align_bits = 3'b001;
            2'd2:    w_align_bits = 3'b011;
            default: w_align_bits = 3'b111;
        endcase
        w_misaligned = |(in_addr_i[2:0] & w_align_bits);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_we        <= 1'b0;
            r_size      <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wen       <= 1'b0;
            r_ren       <= 1'b0;
            r_resp_v    <= 1'b0;
            r_resp_we   <= 1'b0;
            r_resp_err  <= 1'b0;
            r_resp_data <= '0;
`ifdef ETH_MMIO_BRIDGE_TIMEOUT_EN
            r_wait_cnt  <= '0;
`endif
        end else begin
            r_wen <= 1'b0;
            r_ren <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_v_i) begin
                        r_in_ready <= 1'b0;
                        r_we       <= in_we_i;
                        // Misaligned requests never reach the controller, so its bus stays at 0.
                        if (w_misaligned) begin
                            r_state     <= RESP;
                            r_resp_v    <= 1'b1;
                            r_resp_we   <= in_we_i;
                            r_resp_err  <= 1'b1;
                            r_resp_data <= '0;
                        end else begin
                            r_state <= ISSUE;
                            r_addr  <= in_addr_i;
                            r_size  <= in_size_i;
                            r_wdata <= in_data_i & size_mask(in_size_i);
                            r_wen   <= in_we_i;
                            r_ren   <= ~in_we_i;
                        end
                    end
                end
                ISSUE: begin
                    if (r_we) begin
                        r_state     <= RESP;
                        r_resp_v    <= 1'b1;
                        r_resp_we   <= 1'b1;
                        r_resp_err  <= 1'b0;
                        r_resp_data <= '0;
                    end else begin
                        r_state <= WAIT_RD;
`ifdef ETH_MMIO_BRIDGE_TIMEOUT_EN
                        r_wait_cnt <= '0;
`endif
                    end
                end
                WAIT_RD: begin
                    if (read_data_v_i) begin
                        r_state     <= RESP;
                        r_resp_v    <= 1'b1;
                        r_resp_we   <= 1'b0;
                        r_resp_err  <= 1'b0;
                        r_resp_data <= read_data_i & size_mask(r_size);
`ifdef ETH_MMIO_BRIDGE_TIMEOUT_EN
                    end else if (r_wait_cnt == CNT_W'(timeout_cycles_p - 1)) begin
                        r_state     <= RESP;
                        r_resp_v    <= 1'b1;
                        r_resp_we   <= 1'b0;
                        r_resp_err  <= 1'b1;
                        r_resp_data <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        r_state     <= IDLE;
                        r_in_ready  <= 1'b1;
                        r_resp_v    <= 1'b0;
                        r_resp_we   <= 1'b0;
                        r_resp_err  <= 1'b0;
                        r_resp_data <= '0;
                        r_addr      <= '0;
                        r_size      <= '0;
                        r_wdata     <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready_o   = r_in_ready;
    assign resp_v_o     = r_resp_v;
    assign resp_data_o  = r_resp_data;
    assign resp_we_o    = r_resp_we;
    assign resp_err_o   = r_resp_err;
    assign addr_o       = r_addr;
    assign write_en_o   = r_wen;
    assign read_en_o    = r_ren;
    assign op_size_o    = r_size;
    assign write_data_o = r_wdata;

endmodule

// File: tb/tb_ethernet_mmio_bridge.sv
// Bench for ethernet_mmio_bridge: timeline-based transaction model checked every
// cycle, plus literal expectations from directed vectors.
module tb_ethernet_mmio_bridge;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 64;
    localparam int unsigned TO = 8;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          in_v_i = 1'b0;
    logic          in_ready_o;
    logic [AW-1:0] in_addr_i = '0;
    logic          in_we_i = 1'b0;
    logic [1:0]    in_size_i = '0;
    logic [DW-1:0] in_data_i = '0;
    logic          resp_v_o;
    logic          resp_ready_i = 1'b0;
    logic [DW-1:0] resp_data_o;
    logic          resp_we_o;
    logic          resp_err_o;
    logic [AW-1:0] addr_o;
    logic          write_en_o;
    logic          read_en_o;
    logic [1:0]    op_size_o;
    logic [DW-1:0] write_data_o;
    logic [DW-1:0] read_data_i = '0;
    logic          read_data_v_i = 1'b0;

    always #5 clk_i = ~clk_i;

    ethernet_mmio_bridge #(
        .axis_width_p(DW),
        .addr_width_p(AW),
        .timeout_cycles_p(TO)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .in_v_i(in_v_i), .in_ready_o(in_ready_o), .in_addr_i(in_addr_i),
        .in_we_i(in_we_i), .in_size_i(in_size_i), .in_data_i(in_data_i),
        .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
        .resp_we_o(resp_we_o), .resp_err_o(resp_err_o),
        .addr_o(addr_o), .write_en_o(write_en_o), .read_en_o(read_en_o),
        .op_size_o(op_size_o), .write_data_o(write_data_o),
        .read_data_i(read_data_i), .read_data_v_i(read_data_v_i)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] msk(input logic [1:0] size);
        if (size == 2'd3) return '1;
        return (64'd1 << (8 << size)) - 64'd1;
    endfunction

    // Transaction-level model: one live transaction described by its accept cycle
    // and the cycle its response becomes visible (-1 while a read is still pending).
    int          cyc = 0;
    bit          m_busy = 0;
    bit          m_we = 0;
    bit          m_mis = 0;
    bit          m_tout = 0;
    logic [AW-1:0] m_addr = '0;
    logic [1:0]  m_size = '0;
    logic [63:0] m_wdata = '0;
    logic [63:0] m_rdata = '0;
    int          m_tacc = 0;
    int          m_tresp = -1;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            m_busy <= 0;
        end else if (!m_busy) begin
            if (in_v_i) begin
                m_busy  <= 1;
                m_we    <= in_we_i;
                m_mis   <= (int'(in_addr_i) % (1 << in_size_i)) != 0;
                m_tout  <= 0;
                m_addr  <= in_addr_i;
                m_size  <= in_size_i;
                m_wdata <= in_data_i & msk(in_size_i);
                m_rdata <= '0;
                m_tacc  <= cyc;
                if ((int'(in_addr_i) % (1 << in_size_i)) != 0) m_tresp <= cyc + 1;
                else if (in_we_i)                               m_tresp <= cyc + 2;
                else                                            m_tresp <= -1;
            end
        end else if (m_tresp < 0 && cyc >= m_tacc + 2) begin
            if (read_data_v_i) begin
                m_rdata <= read_data_i & msk(m_size);
                m_tresp <= cyc + 1;
`ifdef ETH_MMIO_BRIDGE_TIMEOUT_EN
            end else if (cyc == m_tacc + 2 + int'(TO) - 1) begin
                m_tout  <= 1;
                m_tresp <= cyc + 1;
`endif
            end
        end else if (m_tresp >= 0 && cyc >= m_tresp && resp_ready_i) begin
            m_busy <= 0;
        end
    end

    always @(negedge clk_i) begin
        chk("in_ready", 64'(in_ready_o), 64'(!m_busy));
        chk("write_en", 64'(write_en_o), 64'(m_busy && !m_mis && cyc == m_tacc + 1 && m_we));
        chk("read_en", 64'(read_en_o), 64'(m_busy && !m_mis && cyc == m_tacc + 1 && !m_we));
        chk("addr", 64'(addr_o), (m_busy && !m_mis && cyc >= m_tacc + 1) ? 64'(m_addr) : 64'd0);
        chk("op_size", 64'(op_size_o), (m_busy && !m_mis && cyc >= m_tacc + 1) ? 64'(m_size) : 64'd0);
        chk("write_data", write_data_o, (m_busy && !m_mis && cyc >= m_tacc + 1) ? m_wdata : 64'd0);
        if (m_busy && m_tresp >= 0 && cyc >= m_tresp) begin
            chk("resp_v", 64'(resp_v_o), 64'd1);
            chk("resp_we", 64'(resp_we_o), 64'(m_we));
            chk("resp_err", 64'(resp_err_o), 64'(m_mis || m_tout));
            chk("resp_data", resp_data_o, (m_mis || m_tout || m_we) ? 64'd0 : m_rdata);
        end else begin
            chk("resp_v", 64'(resp_v_o), 64'd0);
            chk("resp_idle", {resp_data_o[61:0], resp_we_o, resp_err_o}, 64'd0);
        end
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic send(input logic we, input logic [AW-1:0] addr, input logic [1:0] size,
                        input logic [63:0] data);
        in_v_i = 1'b1; in_we_i = we; in_addr_i = addr; in_size_i = size; in_data_i = data;
        for (int i = 0; i < 20 && !in_ready_o; i++) step();
        chk("req_accept", 64'(in_ready_o), 64'd1);
        step();
        in_v_i = 1'b0;
    endtask

    task automatic finish_resp(input logic [63:0] exp_d, input logic exp_e);
        for (int i = 0; i < 20 && !resp_v_o; i++) step();
        chk("resp_seen", 64'(resp_v_o), 64'd1);
        chk("resp_lit_data", resp_data_o, exp_d);
        chk("resp_lit_err", 64'(resp_err_o), 64'(exp_e));
        resp_ready_i = 1'b1;
        step();
        resp_ready_i = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [1:0]  size;
        logic [63:0] data;
        int          lat;
        logic [63:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t vecs[6] = '{
        '{1'b1, 16'h0104, 2'd2, 64'hA5A5A5A5_12345678, 0, 64'h0, 1'b0},
        '{1'b0, 16'h0005, 2'd0, 64'h0, 2, 64'h11, 1'b0},
        '{1'b0, 16'h0100, 2'd3, 64'h0, 0, 64'h88776655_44332211, 1'b0},
        '{1'b1, 16'h0001, 2'd1, 64'hFFFF, 0, 64'h0, 1'b1},
        '{1'b0, 16'h0FFE, 2'd1, 64'h0, 1, 64'h2211, 1'b0},
        '{1'b0, 16'h0002, 2'd2, 64'h0, 0, 64'h0, 1'b1}
    };

    initial begin
        repeat (2) @(posedge clk_i);
        #2 reset_n_i = 1'b1;
        step();
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_resp_v", 64'(resp_v_o), 64'd0);

        // Aligned 8B write
        send(1'b1, 16'h0010, 2'd3, 64'h11223344_55667788);
        chk("w8_wen", 64'(write_en_o), 64'd1);
        chk("w8_addr", 64'(addr_o), 64'h10);
        chk("w8_size", 64'(op_size_o), 64'd3);
        chk("w8_wdata", write_data_o, 64'h11223344_55667788);
        step();
        chk("w8_resp_v", 64'(resp_v_o), 64'd1);
        chk("w8_resp_we", 64'(resp_we_o), 64'd1);
        finish_resp(64'd0, 1'b0);

        // 2B read with held response and a spurious pulse in RESP
        send(1'b0, 16'h0802, 2'd1, 64'h0);
        chk("r2_ren", 64'(read_en_o), 64'd1);
        step();
        read_data_i = 64'hDEADBEEF_CAFE1234; read_data_v_i = 1'b1;
        step();
        read_data_v_i = 1'b0; read_data_i = '0;
        chk("r2_resp_v", 64'(resp_v_o), 64'd1);
        chk("r2_data", resp_data_o, 64'h1234);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin read_data_i = '1; read_data_v_i = 1'b1; end
            step();
            read_data_v_i = 1'b0;
            chk("r2_hold", resp_data_o, 64'h1234);
        end
        finish_resp(64'h1234, 1'b0);

        // Misaligned 4B read
        send(1'b0, 16'h0006, 2'd2, 64'h0);
        chk("mis_resp_v", 64'(resp_v_o), 64'd1);
        chk("mis_ren", 64'(read_en_o), 64'd0);
        finish_resp(64'd0, 1'b1);

        // Spurious pulse in IDLE
        read_data_i = 64'h5555; read_data_v_i = 1'b1;
        step();
        read_data_v_i = 1'b0;
        chk("idle_spur_rdy", 64'(in_ready_o), 64'd1);

        foreach (vecs[k]) begin
            send(vecs[k].we, vecs[k].addr, vecs[k].size, vecs[k].data);
            repeat (1 + vecs[k].lat) step();
            read_data_i = 64'h88776655_44332211; read_data_v_i = 1'b1;
            step();
            read_data_v_i = 1'b0;
            finish_resp(vecs[k].exp_d, vecs[k].exp_e);
        end

        // Request held during RESP is not accepted until IDLE
        send(1'b1, 16'h0020, 2'd3, 64'h1);
        step();
        in_v_i = 1'b1; in_we_i = 1'b1; in_addr_i = 16'h0028; in_size_i = 2'd3; in_data_i = 64'h2;
        resp_ready_i = 1'b1;
        step();
        resp_ready_i = 1'b0;
        chk("b2b_ready", 64'(in_ready_o), 64'd1);
        step();
        in_v_i = 1'b0;
        chk("b2b_wen", 64'(write_en_o), 64'd1);
        chk("b2b_addr", 64'(addr_o), 64'h28);
        finish_resp(64'd0, 1'b0);

        // Reset during WAIT_RD
        send(1'b0, 16'h0030, 2'd3, 64'h0);
        step();
        #1 reset_n_i = 1'b0;
        #1;
        chk("arst_resp_v", 64'(resp_v_o), 64'd0);
        chk("arst_addr", 64'(addr_o), 64'd0);
        chk("arst_ready", 64'(in_ready_o), 64'd1);
        step();
        step();
        #1 reset_n_i = 1'b1;
        step();
        chk("post_rst_ready", 64'(in_ready_o), 64'd1);
        send(1'b1, 16'h0003, 2'd0, 64'hAABBCCDD_EEFF0011);
        chk("w1_wen", 64'(write_en_o), 64'd1);
        chk("w1_wdata", write_data_o, 64'h11);
        chk("w1_addr", 64'(addr_o), 64'h3);
        finish_resp(64'd0, 1'b0);

`ifdef ETH_MMIO_BRIDGE_TIMEOUT_EN
        begin
            int waited;
            waited = 0;
            send(1'b0, 16'h0040, 2'd3, 64'h0);
            for (int i = 0; i < 20 && !resp_v_o; i++) begin step(); waited++; end
            chk("tout_latency", 64'(waited), 64'd9);
            read_data_i = 64'h1234; read_data_v_i = 1'b1;
            step();
            read_data_v_i = 1'b0;
            finish_resp(64'd0, 1'b1);
        end
`endif

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
